bus_reg_slave: RTL
==================

BUS_REG_SLAVE -- requirements
Module: bus_reg_slave

Interface
REQ-001 Parameters SHALL be: BAW, default 32, address width.
REQ-002 Parameters SHALL continue: BDW, default 32, data width.
REQ-003 Parameters SHALL continue: NREG, default 16, register count (power of two, >=2).
REQ-004 Ports SHALL be: clk  in  1  system clock, single domain.
REQ-005 Ports SHALL continue: rst  in  1  asynchronous reset, active-low.
REQ-006 Write channel ports SHALL be: wvalid in 1, wready out 1, waddr in BAW, wdata in BDW.
REQ-007 Read-address ports SHALL be: arvalid in 1 (request), arready out 1 (accept), araddr in BAW (word address).
REQ-008 Read-data ports SHALL be: rvalid out 1 (data valid), rready in 1 (master accepts), rdata out BDW, rerr out 1 (address error).

Function
REQ-009 Addresses SHALL be word indices; in range iff addr < NREG; index = addr[$clog2(NREG)-1:0].
REQ-010 wready SHALL be 1 on every cycle out of reset; a write transfers on a posedge with wvalid=1 and wready=1.
REQ-011 A transferred in-range write to index 0..NREG-2 SHALL update that register at that edge.
REQ-012 Index NREG-1 SHALL be a read-only status counter (BDW bits) incrementing by 1 on each transferred write, wrapping to 0 after all-ones; writes to it change nothing else.
REQ-013 Out-of-range writes SHALL be discarded but still counted by REQ-012.
REQ-014 Read FSM SHALL have states IDLE and RESP; arready=1 exactly in IDLE.
REQ-015 IDLE->RESP on a posedge with arvalid=1; rdata/rerr SHALL be loaded at that same edge, so rvalid=1 the following cycle (1-cycle latency).
REQ-016 RESP->IDLE on a posedge with rready=1; rvalid, rdata and rerr SHALL be held stable while rvalid=1 and rready=0.
REQ-017 Maximum read throughput SHALL be one read per two cycles; no read-address skid buffering.
REQ-018 Out-of-range reads SHALL return rdata=0 and rerr=1; in-range reads SHALL return rerr=0.
REQ-019 A write and a read accepted on the same edge to the same index SHALL return the pre-write value; the new value is visible to later reads.
REQ-020 For a status read coinciding with a write, the pre-increment count SHALL be returned.
REQ-021 rdata SHALL be 0 whenever rvalid=0.

Reset
REQ-022 While rst=0: wready=0, arready=0, rvalid=0, rdata=0, rerr=0, FSM=IDLE, all registers and the counter 0.
REQ-023 Reset asserted mid-read SHALL abandon the response immediately (rvalid drops asynchronously); a write on that edge SHALL be lost.
REQ-024 After rst deasserts, wready=1 and arready=1 from the first clock edge.

Structure
REQ-025 Package bus_pkg SHALL hold the read FSM state enum (IDLE, RESP) and the default NREG constant.
REQ-026 Storage SHALL be a sub-module bus_reg_file (NREG-1 x BDW write port, combinational read port); FSM, counter and decode stay in bus_reg_slave.
REQ-027 No latches; all flops use the single clk and asynchronous rst.

Verification
REQ-028 Write addr 3 data 0xDEADBEEF, then read addr 3 -> rvalid one cycle after arvalid accept, rdata=0xDEADBEEF, rerr=0.
REQ-029 Write addr 20 (NREG=16), then read addr 20 -> rdata=0, rerr=1; status (addr 15) reads 1.
REQ-030 Same-edge write addr 5 data 0x11 (previously 0x22) and read addr 5 -> rdata=0x22; next read -> 0x11.
REQ-031 Read addr 3 with rready held 0 for 4 cycles -> rvalid, rdata and rerr stable, arready=0 throughout; completes on the rready=1 edge.
REQ-032 Preload counter 0xFFFFFFFF via 2^32-1 writes (or force), one more write -> status reads 0.
REQ-033 Assert rst while rvalid=1 -> rvalid, wready and arready drop to 0 immediately; register 3 reads 0 after release.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and defaults for the register slave.
package bus_pkg;

  // Default register count; the top index is the read-only write counter.
  localparam int NREG_DEF = 16;

  // Read channel: accept an address in IDLE, present data in RESP.
  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } rd_state_e;

endpackage

// File: rtl/bus_reg_file.sv
// Writable register storage: NREG-1 words, one write port, one combinational
// read port. The top index is not stored here (it is the status counter).
module bus_reg_file
  import bus_pkg::*;
#(
  parameter int BDW  = 32,
  parameter int NREG = NREG_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_we,
  input  logic [$clog2(NREG)-1:0] i_widx,
  input  logic [BDW-1:0]          i_wdata,
  input  logic [$clog2(NREG)-1:0] i_ridx,
  output logic [BDW-1:0]          o_rdata
);

  localparam int AW = $clog2(NREG);
  localparam logic [AW-1:0] LAST = AW'(NREG - 1);

  logic [NREG-2:0][BDW-1:0] r_mem;

  // Storage: cleared asynchronously, one word written per edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      r_mem         <= '0;
    else if (i_we) r_mem[i_widx] <= i_wdata;
  end

  // Read port; indices past the stored range return zero.
  always_comb begin
    o_rdata = '0;
    if (i_ridx < LAST) o_rdata = r_mem[i_ridx];
  end

endmodule

// File: rtl/bus_reg_slave.sv
// Register slave: always-ready write channel, single-outstanding read channel
// with one-cycle latency, and a read-only write counter at the top index.
module bus_reg_slave
  import bus_pkg::*;
#(
  parameter int BAW  = 32,
  parameter int BDW  = 32,
  parameter int NREG = NREG_DEF
) (
  input  logic           clk,
  input  logic           rst,
  // write channel
  input  logic           wvalid,
  output logic           wready,
  input  logic [BAW-1:0] waddr,
  input  logic [BDW-1:0] wdata,
  // read address channel
  input  logic           arvalid,
  output logic           arready,
  input  logic [BAW-1:0] araddr,
  // read data channel
  output logic           rvalid,
  input  logic           rready,
  output logic [BDW-1:0] rdata,
  output logic           rerr
);

  localparam int AW = $clog2(NREG);
  localparam logic [AW-1:0] STAT_IDX = AW'(NREG - 1);

  rd_state_e      r_state, w_state_nxt;
  logic [BDW-1:0] r_cnt;
  logic [BDW-1:0] r_rdata;
  logic           r_rerr;

  logic           w_win, w_rin;
  logic [AW-1:0]  w_widx, w_ridx;
  logic           w_rf_we;
  logic [BDW-1:0] w_rf_rdata;
  logic [BDW-1:0] w_rd_word;
  logic           w_ar_acc, w_r_done;

  // Ready flags follow reset combinationally: low the instant reset asserts,
  // high in time for the first edge after release.
  assign wready  = rst;
  assign arready = rst && (r_state == IDLE);
  assign rvalid  = (r_state == RESP);
  assign rdata   = r_rdata;
  assign rerr    = r_rerr;

  // Address decode: word addresses, in range below NREG.
  assign w_win  = (waddr  < BAW'(NREG));
  assign w_rin  = (araddr < BAW'(NREG));
  assign w_widx = waddr[AW-1:0];
  assign w_ridx = araddr[AW-1:0];

  // Inside the flops wready is known to be 1 (reset branch not taken), so a
  // transfer is simply wvalid. The status index is never stored.
  assign w_rf_we = wvalid && w_win && (w_widx != STAT_IDX);

  bus_reg_file #(
    .BDW  (BDW),
    .NREG (NREG)
  ) u_rf (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_rf_we),
    .i_widx  (w_widx),
    .i_wdata (wdata),
    .i_ridx  (w_ridx),
    .o_rdata (w_rf_rdata)
  );

  // Status counter: counts every transferred write, in range or not.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_cnt <= '0;
    else if (wvalid) r_cnt <= r_cnt + BDW'(1);
  end

  // Read FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Read FSM next state: one address accepted per response round trip.
  always_comb begin
    w_state_nxt = r_state;
    w_ar_acc    = 1'b0;
    w_r_done    = 1'b0;
    case (r_state)
      IDLE: if (arvalid) begin
        w_state_nxt = RESP;
        w_ar_acc    = 1'b1;
      end
      RESP: if (rready) begin
        w_state_nxt = IDLE;
        w_r_done    = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Read word select from pre-edge state, so a same-edge write or counter
  // bump is not visible to this read.
  always_comb begin
    w_rd_word = '0;
    if (w_rin) w_rd_word = (w_ridx == STAT_IDX) ? r_cnt : w_rf_rdata;
  end

  // Response registers: loaded on accept, held while stalled, zeroed on
  // completion so rdata is 0 whenever rvalid is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= '0;
      r_rerr  <= 1'b0;
    end else if (w_ar_acc) begin
      r_rdata <= w_rd_word;
      r_rerr  <= !w_rin;
    end else if (w_r_done) begin
      r_rdata <= '0;
      r_rerr  <= 1'b0;
    end
  end

endmodule
